// File: rtl/cache_replace_pkg.sv
// Shared definitions for the cache replacement block: policy select
// encoding and the LFSR feedback-tap table.
package cache_replace_pkg;

  typedef enum logic [1:0] {
    MODE_PLRU     = 2'b00,
    MODE_RAND     = 2'b01,
    MODE_RR       = 2'b10,
    MODE_PLRU_ALT = 2'b11
  } mode_e;

  // Feedback tap mask for a shift-right Fibonacci LFSR of the given width;
  // bit k set means state bit k is XORed into the new MSB.
  function automatic logic [7:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       return 8'b0000_0011;
      4:       return 8'b0000_0011;
      5:       return 8'b0000_0101;
      6:       return 8'b0000_0011;
      7:       return 8'b0000_0011;
      8:       return 8'b0001_1101;
      default: return 8'b0000_0011;
    endcase
  endfunction

endpackage

// File: rtl/cache_replace_lfsr_gen.sv
// Global free-running LFSR used for random victim selection.
module lfsr_gen
  import cache_replace_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OUTW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  output logic [OUTW-1:0] q
);

  localparam logic [7:0]       TAPS = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] MASK = TAPS[WIDTH-1:0];

  logic [WIDTH-1:0] state;
  logic             fb;

  assign fb = ^(state & MASK);
  assign q  = state[OUTW-1:0];

  // Shift right, feedback into the MSB; seeded with 1 so all-zero never occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WIDTH'(1);
    end else if (advance) begin
      state <= {fb, state[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/cache_replace.sv
// Cache victim selection: per-set tree-PLRU and round-robin state, a global
// LFSR for random replacement, and invalid-way priority.
module cache_replace
  import cache_replace_pkg::*;
#(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned SETLEN   = 9,
  parameter int unsigned NUMLINES = 128,
  parameter int unsigned LFSRLEN  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic               CacheEn,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic               LRUWriteEn,
  input  logic               InvalidateCache,
  input  logic [1:0]         Mode,
  output logic [NUMWAYS-1:0] VictimWay
);

  localparam int unsigned   WAYW  = $clog2(NUMWAYS);
  localparam int unsigned   IDXW  = $clog2(NUMLINES);
  localparam logic [SETLEN:0] LINES = (SETLEN+1)'(NUMLINES);

  logic [NUMWAYS-2:0] plru_mem [NUMLINES];
  logic [WAYW-1:0]    ptr_mem  [NUMLINES];

  logic [NUMWAYS-2:0] rd_plru, cur_plru, new_plru;
  logic [WAYW-1:0]    rd_ptr, cur_ptr, new_ptr;
  logic [IDXW-1:0]    rd_idx, wr_idx;
  logic               rd_ok, wr_ok, upd, fill, bypass;
  logic [NUMWAYS-1:0] used_oh, plru_oh, invalid_oh, policy_oh;
  logic [WAYW-1:0]    used_idx, lfsr_low;

  assign rd_ok    = {1'b0, CacheSetData} < LINES;
  assign wr_ok    = {1'b0, CacheSetTag} < LINES;
  assign rd_idx   = CacheSetData[IDXW-1:0];
  assign wr_idx   = CacheSetTag[IDXW-1:0];
  assign cur_plru = plru_mem[wr_idx];
  assign cur_ptr  = ptr_mem[wr_idx];
  assign fill     = ~|HitWay;
  assign upd      = LRUWriteEn & ~FlushStage & wr_ok;
  assign bypass   = upd & rd_ok & (wr_idx == rd_idx);
  assign new_ptr  = cur_ptr + WAYW'(1);
  assign used_oh  = fill ? VictimWay : HitWay;

  lfsr_gen #(
    .WIDTH (LFSRLEN),
    .OUTW  (WAYW)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (~FlushStage),
    .q       (lfsr_low)
  );

  // Encode the one-hot used way into an index for the tree update.
  always_comb begin
    used_idx = '0;
    for (int unsigned i = 0; i < NUMWAYS; i++) begin
      if (used_oh[i]) used_idx = WAYW'(i);
    end
  end

  // Tree update: node n (heap order) sits on the used way's path when the way's
  // top LVL index bits equal the node's position within its level.
  for (genvar n = 0; n < NUMWAYS - 1; n++) begin : g_upd
    localparam int unsigned LVL = $clog2(n + 2) - 1;
    localparam int unsigned POS = n + 1 - (1 << LVL);
    logic on_path;
    assign on_path     = (used_idx >> (WAYW - LVL)) == WAYW'(POS);
    assign new_plru[n] = on_path ? ~used_idx[WAYW-1-LVL] : cur_plru[n];
  end

  // Tree walk: a way is the PLRU victim when every node on its path points to it.
  for (genvar w = 0; w < NUMWAYS; w++) begin : g_walk
    logic [WAYW-1:0] step_ok;
    for (genvar l = 0; l < WAYW; l++) begin : g_lvl
      localparam int unsigned NODE = (1 << l) - 1 + (w >> (WAYW - l));
      localparam logic        DIR  = ((w >> (WAYW - 1 - l)) & 1) != 0;
      assign step_ok[l] = rd_plru[NODE] == DIR;
    end
    assign plru_oh[w] = &step_ok;
  end

  // Victim choice; ~V & (V+1) isolates the lowest zero bit of ValidWay.
  always_comb begin
    invalid_oh = ~ValidWay & (ValidWay + NUMWAYS'(1));
    case (mode_e'(Mode))
      MODE_RAND:     policy_oh = NUMWAYS'(1) << lfsr_low;
      MODE_RR:       policy_oh = NUMWAYS'(1) << rd_ptr;
      MODE_PLRU,
      MODE_PLRU_ALT: policy_oh = plru_oh;
      default:       policy_oh = plru_oh;
    endcase
    VictimWay = (|invalid_oh) ? invalid_oh : policy_oh;
  end

  // Per-set state arrays and the read register, with same-set write bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUMLINES; i++) begin
        plru_mem[IDXW'(i)] <= '0;
        ptr_mem[IDXW'(i)]  <= '0;
      end
      rd_plru <= '0;
      rd_ptr  <= '0;
    end else if (InvalidateCache) begin
      for (int unsigned i = 0; i < NUMLINES; i++) begin
        plru_mem[IDXW'(i)] <= '0;
        ptr_mem[IDXW'(i)]  <= '0;
      end
      rd_plru <= '0;
      rd_ptr  <= '0;
    end else begin
      if (upd) begin
        plru_mem[wr_idx] <= new_plru;
        if (fill) ptr_mem[wr_idx] <= new_ptr;
      end
      if (CacheEn) begin
        if (!rd_ok) begin
          rd_plru <= '0;
          rd_ptr  <= '0;
        end else if (bypass) begin
          rd_plru <= new_plru;
          rd_ptr  <= fill ? new_ptr : cur_ptr;
        end else begin
          rd_plru <= plru_mem[rd_idx];
          rd_ptr  <= ptr_mem[rd_idx];
        end
      end
    end
  end

endmodule
